// File: rtl/pcm_pkg.sv
// Shared widths, saturation/rounding constants and the {chan, sample} FIFO entry type
// for the PCM sample buffer.
package pcm_pkg;

  localparam int IN_W      = 18;
  localparam int OUT_W     = 16;
  localparam int ROUND_ADD = 2;

  localparam logic [OUT_W-1:0] POS_SAT = 16'h7FFF;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  typedef struct packed {
    logic             chan;
    logic [OUT_W-1:0] sample;
  } entry_t;

endpackage

// File: rtl/pcm_fifo.sv
// Synchronous first-word-fall-through FIFO: the head entry is visible combinationally,
// a write to a full FIFO is accepted only when a read frees a slot in the same cycle.
module pcm_fifo
  import pcm_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  entry_t                   wr_data,
  input  logic                     rd_en,
  output entry_t                   rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     wr_drop
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          wr_acc, rd_acc;

  entry_t mem_q [DEPTH];

  always_comb begin
    full    = (level_q == LW'(DEPTH));
    empty   = (level_q == '0);
    rd_acc  = rd_en & ~empty;
    wr_acc  = wr_en & (~full | rd_acc);
    wr_drop = wr_en & ~wr_acc;

    wr_ptr_d = wr_acc ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + PW'(1) : rd_ptr_q;

    level_d = level_q;
    if (wr_acc && !rd_acc) begin
      level_d = level_q + LW'(1);
    end else if (rd_acc && !wr_acc) begin
      level_d = level_q - LW'(1);
    end

    // Stale storage is hidden while empty so the output is deterministic.
    rd_data = empty ? '0 : mem_q[rd_ptr_q];
    level   = level_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/pcm_sample_buffer.sv
// Captures one I2S sample per rising `done`, rounds/saturates 18->16 bit, and queues it
// (2-cycle capture latency); consumer drains via rd_valid/rd_ready, drops set sticky overflow.
module pcm_sample_buffer #(
  parameter int DEPTH = 16,
  parameter int IN_W  = 18,
  parameter int OUT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [IN_W-1:0]        data_in,
  input  logic                   done,
  input  logic                   ws,
  input  logic                   rd_ready,
  input  logic                   clr_ovf,
  output logic                   rd_valid,
  output logic [OUT_W-1:0]       rd_data,
  output logic                   rd_chan,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   overflow
);

  import pcm_pkg::*;

  localparam int SHIFT = IN_W - OUT_W;

  logic                 done_q, done_d;
  logic                 stg_valid_q, stg_valid_d;
  entry_t               stg_q, stg_d;
  logic                 ovf_q, ovf_d;
  logic                 cap;
  logic signed [IN_W:0] rnd_s, shr_s;
  logic [OUT_W-1:0]     conv_sample;
  logic                 rd_en, empty, wr_drop;
  entry_t               head;

  // One extra bit of headroom keeps the +2 round of the most positive sample from wrapping.
  always_comb begin
    rnd_s = $signed({data_in[IN_W-1], data_in}) + $signed((IN_W+1)'(ROUND_ADD));
    shr_s = rnd_s >>> SHIFT;
    if (!shr_s[IN_W] && (|shr_s[IN_W-1:OUT_W-1])) begin
      conv_sample = POS_SAT;
    end else begin
      conv_sample = shr_s[OUT_W-1:0];
    end
  end

  always_comb begin
    cap         = done & ~done_q & enable;
    done_d      = done;
    stg_valid_d = cap;
    stg_d       = stg_q;
    if (cap) begin
      stg_d.chan   = ws ? CH_RIGHT : CH_LEFT;
      stg_d.sample = conv_sample;
    end
    // A drop in the same cycle as a clear must leave the flag set.
    ovf_d = wr_drop | (ovf_q & ~clr_ovf);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      done_q      <= 1'b1;
      stg_valid_q <= 1'b0;
      stg_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      done_q      <= done_d;
      stg_valid_q <= stg_valid_d;
      stg_q       <= stg_d;
      ovf_q       <= ovf_d;
    end
  end

  assign rd_valid = ~empty;
  assign rd_en    = rd_valid & rd_ready;
  assign rd_data  = head.sample;
  assign rd_chan  = head.chan;
  assign overflow = ovf_q;

  pcm_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (stg_valid_q),
    .wr_data (stg_q),
    .rd_en   (rd_en),
    .rd_data (head),
    .level   (level),
    .full    (full),
    .empty   (empty),
    .wr_drop (wr_drop)
  );

endmodule

// File: tb/tb_pcm_sample_buffer.sv
// Directed stimulus for pcm_sample_buffer, checked every cycle against a queue-based model
// plus hand-computed expectations at key points.
module tb_pcm_sample_buffer;

  localparam int DEPTH = 16;

  logic        clk      = 1'b0;
  logic        reset    = 1'b0;
  logic        enable   = 1'b1;
  logic        done     = 1'b1;
  logic        ws       = 1'b0;
  logic        rd_ready = 1'b0;
  logic        clr_ovf  = 1'b0;
  logic [17:0] data_in  = '0;

  logic        rd_valid;
  logic [15:0] rd_data;
  logic        rd_chan;
  logic [4:0]  level;
  logic        full;
  logic        overflow;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pcm_sample_buffer #(
    .DEPTH (DEPTH),
    .IN_W  (18),
    .OUT_W (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .data_in  (data_in),
    .done     (done),
    .ws       (ws),
    .rd_ready (rd_ready),
    .clr_ovf  (clr_ovf),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_chan  (rd_chan),
    .level    (level),
    .full     (full),
    .overflow (overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Round half up by quarter steps, clamp only on the positive side.
  function automatic logic [15:0] conv(input logic [17:0] d);
    int v;
    v = int'($signed(d));
    v = (v + 2) >>> 2;
    if (v > 32767) return 16'h7FFF;
    return v[15:0];
  endfunction

  logic [16:0] mq[$];
  logic        m_ovf       = 1'b0;
  logic        m_pend      = 1'b0;
  logic [16:0] m_pend_e    = '0;
  logic        m_prev_done = 1'b1;
  logic        m_drop      = 1'b0;
  bit          m_on        = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      mq.delete();
      m_ovf       = 1'b0;
      m_pend      = 1'b0;
      m_prev_done = 1'b1;
      m_on        = 1'b1;
    end else begin
      m_drop = 1'b0;
      if (mq.size() != 0 && rd_ready) void'(mq.pop_front());
      if (m_pend) begin
        if (mq.size() < DEPTH) mq.push_back(m_pend_e);
        else m_drop = 1'b1;
      end
      if (m_drop) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
      m_pend      = done && !m_prev_done && enable;
      m_pend_e    = {ws, conv(data_in)};
      m_prev_done = done;
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      check("m_rd_valid", rd_valid, mq.size() != 0);
      check("m_level", level, mq.size());
      check("m_full", full, mq.size() == DEPTH);
      check("m_overflow", overflow, m_ovf);
      check("m_rd_data", rd_data, (mq.size() != 0) ? mq[0][15:0] : 16'h0);
      check("m_rd_chan", rd_chan, (mq.size() != 0) ? mq[0][16] : 1'b0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [17:0] d, input logic ch);
    tick();
    data_in = d;
    ws      = ch;
    done    = 1'b1;
    tick();
    tick();
    done = 1'b0;
    tick();
  endtask

  task automatic expect_head(input string name, input logic [15:0] d, input logic ch);
    @(negedge clk);
    check({name, "_vld"}, rd_valid, 1'b1);
    check({name, "_data"}, rd_data, d);
    check({name, "_chan"}, rd_chan, ch);
    rd_ready = 1'b1;
    @(posedge clk);
    #1;
    rd_ready = 1'b0;
  endtask

  task automatic drain_and_clear();
    rd_ready = 1'b1;
    repeat (DEPTH + 1) tick();
    rd_ready = 1'b0;
    clr_ovf  = 1'b1;
    tick();
    clr_ovf = 1'b0;
  endtask

  initial begin
    // Reset with done held high; its level at release must not count as an edge.
    repeat (3) tick();
    reset = 1'b1;
    repeat (20) tick();
    @(negedge clk);
    check("hold_done_level", level, 5'd0);
    check("hold_done_vld", rd_valid, 1'b0);
    check("reset_ovf", overflow, 1'b0);
    check("reset_data", rd_data, 16'h0);
    done = 1'b0;
    tick();

    // First capture latency: visible in C2.
    tick();
    data_in = 18'h00006;
    ws      = 1'b0;
    done    = 1'b1;
    @(negedge clk);
    check("lat_c0_vld", rd_valid, 1'b0);
    @(negedge clk);
    check("lat_c1_vld", rd_valid, 1'b0);
    @(negedge clk);
    check("lat_c2_vld", rd_valid, 1'b1);
    check("lat_c2_data", rd_data, 16'h0002);
    check("lat_c2_chan", rd_chan, 1'b0);
    rd_ready = 1'b1;
    @(posedge clk);
    #1;
    rd_ready = 1'b0;
    done     = 1'b0;
    tick();

    // Conversion corners.
    send(18'h1FFFF, 1'b1);
    send(18'h20000, 1'b0);
    send(18'h3FFFE, 1'b1);
    expect_head("pos_sat", 16'h7FFF, 1'b1);
    expect_head("neg_min", 16'h8000, 1'b0);
    expect_head("neg_two", 16'h0000, 1'b1);

    // 17 captures into 16 slots.
    for (int i = 0; i < 17; i++) send(18'(i * 4), i[0]);
    @(negedge clk);
    check("ovf_full", full, 1'b1);
    check("ovf_level", level, 5'd16);
    check("ovf_flag", overflow, 1'b1);
    for (int i = 0; i < 16; i++) expect_head($sformatf("order%0d", i), 16'(i), i[0]);

    tick();
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    @(negedge clk);
    check("ovf_cleared", overflow, 1'b0);

    // Write into a full FIFO while the consumer reads in the same cycle.
    for (int i = 0; i < 16; i++) send(18'(i * 4), i[0]);
    tick();
    data_in = 18'(16 * 4);
    ws      = 1'b0;
    done    = 1'b1;
    tick();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    done     = 1'b0;
    @(negedge clk);
    check("rw_full_level", level, 5'd16);
    check("rw_full_ovf", overflow, 1'b0);
    for (int i = 1; i <= 16; i++) expect_head($sformatf("rw_order%0d", i), 16'(i), i[0]);

    // Drop coinciding with clr_ovf.
    for (int i = 0; i < 16; i++) send(18'(i * 4 + 1), i[0]);
    tick();
    data_in = 18'h00400;
    ws      = 1'b1;
    done    = 1'b1;
    tick();
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    done    = 1'b0;
    @(negedge clk);
    check("set_wins_ovf", overflow, 1'b1);
    drain_and_clear();
    @(negedge clk);
    check("drained_level", level, 5'd0);
    check("drained_ovf", overflow, 1'b0);

    // Disabled capture.
    enable = 1'b0;
    send(18'h00100, 1'b1);
    enable = 1'b1;
    tick();
    @(negedge clk);
    check("en_off_level", level, 5'd0);
    check("en_off_vld", rd_valid, 1'b0);

    // Reset with entries stored.
    for (int i = 0; i < 5; i++) send(18'(i * 8), i[0]);
    @(negedge clk);
    check("pre_rst_level", level, 5'd5);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_vld", rd_valid, 1'b0);
    check("mid_rst_level", level, 5'd0);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
